// File: rtl/switch_debounce_toggle.sv
// rtl/switch_debounce_toggle.sv - two-switch debouncer with release-toggle LED and AND LED
//
// Purpose: filters two raw push-switch levels. A new level is accepted only
// after it has been sampled for DEBOUNCE_LIMIT consecutive clocks. Switch 1
// also produces press/release pulses and a LED that toggles on each release.
// The second LED shows the registered AND of both debounced switches.
//
// Optional feature macro: SWITCH_SYNC_EN. When defined, a two-flop
// synchronizer sits in front of each sample flop, adding 2 clocks of latency.
//
// Ports:
//   i_Clk            - single clock, rising edge
//   i_Reset          - synchronous active-high reset
//   i_Switch_1/2     - raw bouncing switch levels (1 = pressed)
//   o_Switch_1/2_Clean - debounced levels (the stable bits themselves)
//   o_Switch_1_Rise  - one-clock pulse on debounced press of switch 1
//   o_Switch_1_Fall  - one-clock pulse on debounced release of switch 1
//   o_LED_1          - toggles on each debounced release of switch 1
//   o_LED_2          - registered AND of both debounced switches

module switch_debounce_toggle #(
  parameter int DEBOUNCE_LIMIT = 250000
) (
  input  logic i_Clk,
  input  logic i_Reset,
  input  logic i_Switch_1,
  input  logic i_Switch_2,
  output logic o_Switch_1_Clean,
  output logic o_Switch_2_Clean,
  output logic o_Switch_1_Rise,
  output logic o_Switch_1_Fall,
  output logic o_LED_1,
  output logic o_LED_2
);

  localparam int CW = (DEBOUNCE_LIMIT > 1) ? $clog2(DEBOUNCE_LIMIT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_LIMIT - 1);

  // Index 0 is switch 1, index 1 is switch 2.
  logic [1:0] src_s;

`ifdef SWITCH_SYNC_EN
  logic [1:0] sync1_q;
  logic [1:0] sync2_q;

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
    end else begin
      sync1_q <= {i_Switch_2, i_Switch_1};
      sync2_q <= sync1_q;
    end
  end

  assign src_s = sync2_q;
`else
  assign src_s = {i_Switch_2, i_Switch_1};
`endif

  logic [1:0]    sample_q, sample_d;
  logic [1:0]    stable_q, stable_d;
  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic          led1_q, led1_d;
  logic          led2_q, led2_d;

  always_comb begin
    sample_d = src_s;
    stable_d = stable_q;
    for (int i = 0; i < 2; i++) begin
      // Counter only runs while the sample disagrees with the stable level;
      // any agreement (a bounce back) discards the partial count.
      cnt_d[i] = '0;
      if (sample_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          stable_d[i] = sample_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
    // Edge pulses are decoded from the next stable value so they register
    // on the same edge that updates the stable bit.
    rise_d = ~stable_q[0] &  stable_d[0];
    fall_d =  stable_q[0] & ~stable_d[0];
    led1_d = led1_q ^ fall_d;
    led2_d = stable_q[0] & stable_q[1];
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      sample_q <= 2'b00;
      stable_q <= 2'b00;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      led1_q   <= 1'b0;
      led2_q   <= 1'b0;
    end else begin
      sample_q <= sample_d;
      stable_q <= stable_d;
      cnt_q[0] <= cnt_d[0];
      cnt_q[1] <= cnt_d[1];
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      led1_q   <= led1_d;
      led2_q   <= led2_d;
    end
  end

  assign o_Switch_1_Clean = stable_q[0];
  assign o_Switch_2_Clean = stable_q[1];
  assign o_Switch_1_Rise  = rise_q;
  assign o_Switch_1_Fall  = fall_q;
  assign o_LED_1          = led1_q;
  assign o_LED_2          = led2_q;

endmodule

// File: doc/switch_debounce_toggle.md
SWITCH_DEBOUNCE_TOGGLE -- requirements
Module: switch_debounce_toggle

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_LIMIT, default 250000, meaning the number of consecutive clocks a switch must hold a new level before it is accepted (10 ms at 25 MHz).
REQ-002 The block SHALL have port i_Clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port i_Reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have ports i_Switch_1 and i_Switch_2, input, 1 bit each: raw, bouncing, asynchronous push-switch levels (1 = pressed).
REQ-005 The block SHALL have ports o_Switch_1_Clean and o_Switch_2_Clean, output, 1 bit each: debounced switch levels.
REQ-006 The block SHALL have ports o_Switch_1_Rise and o_Switch_1_Fall, output, 1 bit each: one-clock pulses on debounced press and release of switch 1.
REQ-007 The block SHALL have port o_LED_1, output, 1 bit: toggles on each debounced release of switch 1.
REQ-008 The block SHALL have port o_LED_2, output, 1 bit: registered AND of both debounced switches.

Function
REQ-009 Each switch SHALL have an independent filter: a sample bit, a stable bit, and a counter of width ceil(log2(DEBOUNCE_LIMIT)) bits, minimum 1 bit.
REQ-010 While sample equals stable, the counter SHALL be 0.
REQ-011 While sample differs from stable, the counter SHALL increment by 1 per clock.
REQ-012 On the clock where sample differs from stable and counter equals DEBOUNCE_LIMIT-1, stable SHALL take the sample value and the counter SHALL clear.
REQ-013 Without synchronizer stages, stable SHALL change exactly DEBOUNCE_LIMIT clocks after the first differing sample.
REQ-014 Any return of sample to the stable level before the limit is reached SHALL clear the counter; the count is not preserved across bounces.
REQ-015 The counter SHALL never exceed DEBOUNCE_LIMIT-1 and SHALL never wrap.
REQ-016 o_Switch_n_Clean SHALL equal the stable bit directly, with no extra register.
REQ-017 o_Switch_1_Rise SHALL be high for exactly the one clock after stable_1 goes 0->1; o_Switch_1_Fall SHALL do the same for 1->0.
REQ-018 Rise and Fall SHALL never both be high, and each SHALL be registered in the same clock edge that updates stable_1.
REQ-019 o_LED_1 SHALL invert on the same clock edge that asserts o_Switch_1_Fall.
REQ-020 o_LED_1 SHALL NOT change on press or on bounces.
REQ-021 o_LED_2 SHALL be registered from the stable bits, giving one clock of latency after either clean output changes.
REQ-022 Simultaneous transitions on both switches SHALL be filtered independently, with no interaction between the two filters.
REQ-023 With DEBOUNCE_LIMIT=1, every sampled change SHALL be accepted on the next clock.

Reset
REQ-024 While i_Reset is high at a clock edge, the following SHALL all be cleared to 0:
- sample bits, stable bits and counters;
- synchronizer flops (when present);
- o_Switch_n_Clean, o_Switch_1_Rise, o_Switch_1_Fall, o_LED_1 and o_LED_2.
REQ-025 Reset asserted during a count SHALL discard the partial count.
REQ-026 A switch held pressed through reset SHALL be re-debounced from 0 after reset release, producing a Rise pulse DEBOUNCE_LIMIT clocks after the first post-reset sample.
REQ-027 Reset SHALL take no asynchronous action.

Configuration
REQ-028 When macro SWITCH_SYNC_EN is defined, each raw switch SHALL pass through a two-flop synchronizer before its sample bit, adding exactly 2 clocks to every latency above.
REQ-029 When SWITCH_SYNC_EN is undefined, the sample bit SHALL register the raw input directly (single flop); all other behaviour SHALL be identical.

Verification (DEBOUNCE_LIMIT=4, SWITCH_SYNC_EN undefined unless stated)
REQ-030 Clean press: i_Switch_1 0->1 and held -> o_Switch_1_Clean=1 on the 5th edge after the change (1 sample + 4 count), o_Switch_1_Rise high for exactly 1 clock, o_LED_1 unchanged at 0.
REQ-031 Bounce: i_Switch_1 pattern 1,0,1,1,0 at successive clocks, then 0 held -> o_Switch_1_Clean stays 0, no Rise pulse, counter observed to return to 0.
REQ-032 Toggle: three full press/release cycles, each level held 10 clocks -> o_LED_1 sequence 0->1->0->1, changing on the Fall pulse edges only.
REQ-033 AND output: switch 1 pressed and held, then switch 2 pressed and held -> o_LED_2=1 one clock after o_Switch_2_Clean rises; o_LED_2=0 one clock after either switch is released.
REQ-034 Reset mid-count: switch 1 held high, i_Reset pulsed for 1 clock at count=2 -> all outputs 0, then Rise 5 clocks after reset deassertion.
REQ-035 SWITCH_SYNC_EN defined: repeat the REQ-030 stimulus -> Clean rises on the 7th edge after the change.
